// File: rtl/mkmif_sram_model.sv
// SPI mode-0 SRAM responder modelling the 23K640 command set (READ, WRITE,
// RDSR, WRSR). All SPI inputs are brought into the clk domain through
// 2-flop synchronizers, and edges are detected on the synchronized samples.
module mkmif_sram_model #(
   parameter int unsigned ADDR_BITS = 13
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       spi_sclk,
   input  logic       spi_cs_n,
   input  logic       spi_di,
   output logic       spi_do,
   output logic [7:0] status
);

   typedef enum logic [3:0] {
      ST_IDLE, ST_CMD, ST_ADDR_HI, ST_ADDR_LO, ST_RD_DATA,
      ST_WR_DATA, ST_RDSR, ST_WRSR, ST_IGNORE
   } state_t;

   localparam logic [7:0] CMD_READ  = 8'h03;
   localparam logic [7:0] CMD_WRITE = 8'h02;
   localparam logic [7:0] CMD_RDSR  = 8'h05;
   localparam logic [7:0] CMD_WRSR  = 8'h01;

   logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
   logic cs_meta_q, cs_sync_q, cs_prev_q;
   logic di_meta_q, di_sync_q;

   state_t               state_q, state_d;
   logic [2:0]           bit_cnt_q, bit_cnt_d;
   logic [6:0]           shift_q, shift_d;
   logic [7:0]           addr_hi_q, addr_hi_d;
   logic [ADDR_BITS-1:0] addr_q, addr_d;
   logic                 is_read_q, is_read_d;
   logic                 wrote_q, wrote_d;
   logic [7:0]           tx_q, tx_d;
   logic                 do_q, do_d;
   logic [7:0]           status_q, status_d;

   logic [7:0]           mem [2**ADDR_BITS];

   logic                 sclk_rise, sclk_fall, cs_rise, cs_fall;
   logic [7:0]           rx_byte;
   logic [4:0]           page_lo;
   logic [ADDR_BITS-1:0] addr_next, addr_load;
   logic                 byte_mode;
   logic                 mem_we;

   // Two-flop synchronizers plus one delayed copy for edge detection
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sclk_meta_q <= 1'b0;
         sclk_sync_q <= 1'b0;
         sclk_prev_q <= 1'b0;
         cs_meta_q   <= 1'b1;
         cs_sync_q   <= 1'b1;
         cs_prev_q   <= 1'b1;
         di_meta_q   <= 1'b0;
         di_sync_q   <= 1'b0;
      end else begin
         sclk_meta_q <= spi_sclk;
         sclk_sync_q <= sclk_meta_q;
         sclk_prev_q <= sclk_sync_q;
         cs_meta_q   <= spi_cs_n;
         cs_sync_q   <= cs_meta_q;
         cs_prev_q   <= cs_sync_q;
         di_meta_q   <= spi_di;
         di_sync_q   <= di_meta_q;
      end
   end

   assign sclk_rise = sclk_sync_q & ~sclk_prev_q;
   assign sclk_fall = ~sclk_sync_q & sclk_prev_q;
   assign cs_rise   = cs_sync_q & ~cs_prev_q;
   assign cs_fall   = ~cs_sync_q & cs_prev_q;
   assign rx_byte   = {shift_q, di_sync_q};
   assign byte_mode = (status_q[7:6] == 2'b00) || (status_q[7:6] == 2'b11);
   assign page_lo   = addr_q[4:0] + 5'd1;
   assign addr_load = ADDR_BITS'({addr_hi_q, rx_byte});

   // Post-byte address advance according to the status mode bits
   always_comb begin
      addr_next = addr_q;
      case (status_q[7:6])
         2'b01:   addr_next = addr_q + ADDR_BITS'(1);
         2'b10:   addr_next = {addr_q[ADDR_BITS-1:5], page_lo};
         default: addr_next = addr_q;
      endcase
   end

   // Command FSM: cs_n edges take priority over sclk edges
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      addr_hi_d = addr_hi_q;
      addr_d    = addr_q;
      is_read_d = is_read_q;
      wrote_d   = wrote_q;
      tx_d      = tx_q;
      do_d      = do_q;
      status_d  = status_q;
      mem_we    = 1'b0;

      if (cs_rise) begin
         state_d   = ST_IDLE;
         bit_cnt_d = '0;
         shift_d   = '0;
         do_d      = 1'b0;
      end else if (cs_fall) begin
         state_d   = ST_CMD;
         bit_cnt_d = '0;
         shift_d   = '0;
         wrote_d   = 1'b0;
         do_d      = 1'b0;
      end else if (state_q != ST_IDLE && !cs_sync_q) begin
         if (sclk_rise) begin
            shift_d   = rx_byte[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
               case (state_q)
                  ST_CMD: begin
                     case (rx_byte)
                        CMD_READ:  begin is_read_d = 1'b1; state_d = ST_ADDR_HI; end
                        CMD_WRITE: begin is_read_d = 1'b0; state_d = ST_ADDR_HI; end
                        CMD_RDSR:  begin tx_d = status_q; state_d = ST_RDSR; end
                        CMD_WRSR:  state_d = ST_WRSR;
                        default:   state_d = ST_IGNORE;
                     endcase
                  end
                  ST_ADDR_HI: begin
                     addr_hi_d = rx_byte;
                     state_d   = ST_ADDR_LO;
                  end
                  ST_ADDR_LO: begin
                     addr_d = addr_load;
                     if (is_read_q) begin
                        tx_d    = mem[addr_load];
                        state_d = ST_RD_DATA;
                     end else begin
                        state_d = ST_WR_DATA;
                     end
                  end
                  ST_RD_DATA: begin
                     addr_d = addr_next;
                     tx_d   = mem[addr_next];
                  end
                  ST_WR_DATA: begin
                     mem_we  = !(byte_mode && wrote_q);
                     wrote_d = 1'b1;
                     addr_d  = addr_next;
                  end
                  ST_RDSR: tx_d = status_q;
                  ST_WRSR: begin
                     status_d = {rx_byte[7:6], 5'b00000, rx_byte[0]};
                     state_d  = ST_IGNORE;
                  end
                  default: ;
               endcase
            end
         end else if (sclk_fall) begin
            if (state_q == ST_RD_DATA || state_q == ST_RDSR) begin
               do_d = tx_q[7];
               tx_d = {tx_q[6:0], 1'b0};
            end
         end
      end
   end

   // FSM and datapath registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         addr_hi_q <= '0;
         addr_q    <= '0;
         is_read_q <= 1'b0;
         wrote_q   <= 1'b0;
         tx_q      <= '0;
         do_q      <= 1'b0;
         status_q  <= '0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         addr_hi_q <= addr_hi_d;
         addr_q    <= addr_d;
         is_read_q <= is_read_d;
         wrote_q   <= wrote_d;
         tx_q      <= tx_d;
         do_q      <= do_d;
         status_q  <= status_d;
      end
   end

   // Storage array; deliberately not reset so contents survive reset
   always_ff @(posedge clk) begin
      if (mem_we) mem[addr_q] <= rx_byte;
   end

   assign spi_do = do_q;
   assign status = status_q;

endmodule

// File: tb/tb_mkmif_sram_model.sv
// Scoreboard bench for mkmif_sram_model: a SPI master task drives
// transactions, a reference model predicts read/status bytes into a queue,
// and a monitor on sclk rising edges assembles received bytes and compares.
module tb_mkmif_sram_model;

   localparam int ABITS = 13;
   localparam int MSIZE = 1 << ABITS;
   localparam int HALF  = 60;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       spi_sclk = 1'b0;
   logic       spi_cs_n = 1'b1;
   logic       spi_di = 1'b0;
   logic       spi_do;
   logic [7:0] status;

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_q[$];
   logic       cap_en = 1'b0;
   logic       zero_en = 1'b0;
   int         mon_bits = 0;
   logic [7:0] mon_sh = '0;

   logic [7:0] mem_m [MSIZE];
   logic [7:0] st_m = 8'h00;

   mkmif_sram_model #(.ADDR_BITS(ABITS)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .spi_sclk (spi_sclk),
      .spi_cs_n (spi_cs_n),
      .spi_di   (spi_di),
      .spi_do   (spi_do),
      .status   (status)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%02h expected=%02h", name, act, exp);
      end
   endtask

   // Monitor: master samples spi_do on each sclk rising edge
   always @(posedge spi_sclk) begin
      if (zero_en) check("do_zero", {7'd0, spi_do}, 8'h00);
      if (cap_en) begin
         mon_sh = {mon_sh[6:0], spi_do};
         mon_bits++;
         if (mon_bits == 8) begin
            mon_bits = 0;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rx_unexpected actual=%02h expected=none", mon_sh);
            end else begin
               check("rx_byte", mon_sh, exp_q.pop_front());
            end
         end
      end else begin
         mon_bits = 0;
      end
   end

   // Reference address advance derived from the status mode bits
   function automatic int adv(input int a);
      case (st_m[7:6])
         2'b01:   return (a + 1) % MSIZE;
         2'b10:   return (a / 32) * 32 + ((a + 1) % 32);
         default: return a;
      endcase
   endfunction

   task automatic spi_bits(input logic [7:0] b, input int n);
      for (int i = 0; i < n; i++) begin
         spi_di = b[7-i];
         #HALF spi_sclk = 1'b1;
         #HALF spi_sclk = 1'b0;
      end
      spi_di = 1'b0;
   endtask

   task automatic txn(input logic [7:0] hdr[$], input int rd_n, input int abort_bits);
      spi_cs_n = 1'b0;
      #HALF;
      zero_en = 1'b1;
      foreach (hdr[k]) spi_bits(hdr[k], 8);
      if (abort_bits > 0) spi_bits(8'($urandom), abort_bits);
      zero_en = 1'b0;
      cap_en = 1'b1;
      repeat (rd_n) spi_bits(8'h00, 8);
      cap_en = 1'b0;
      #HALF spi_cs_n = 1'b1;
      #(2*HALF);
   endtask

   task automatic wrsr(input logic [7:0] v);
      logic [7:0] h[$];
      h = '{8'h01, v};
      txn(h, 0, 0);
      st_m = {v[7:6], 5'b00000, v[0]};
      check("status_after_wrsr", status, st_m);
   endtask

   task automatic rdsr(input int n);
      logic [7:0] h[$];
      h = '{8'h05};
      repeat (n) exp_q.push_back(st_m);
      txn(h, n, 0);
   endtask

   task automatic mwrite(input int addr, input logic [7:0] d[$], input int abort_bits);
      logic [7:0] h[$];
      int a;
      h = '{8'h02, 8'(addr >> 8), 8'(addr)};
      a = addr % MSIZE;
      foreach (d[k]) begin
         h.push_back(d[k]);
         if (k == 0 || st_m[7:6] == 2'b01 || st_m[7:6] == 2'b10) mem_m[a] = d[k];
         a = adv(a);
      end
      txn(h, 0, abort_bits);
   endtask

   task automatic mread(input int addr, input int n);
      logic [7:0] h[$];
      int a;
      h = '{8'h03, 8'(addr >> 8), 8'(addr)};
      a = addr % MSIZE;
      repeat (n) begin
         exp_q.push_back(mem_m[a]);
         a = adv(a);
      end
      txn(h, n, 0);
   endtask

   initial begin
      logic [7:0] d[$];
      logic [7:0] h[$];
      int addr, n;

      #33 reset_n = 1'b1;
      #50;
      check("reset_status", status, 8'h00);
      check("reset_do", {7'd0, spi_do}, 8'h00);
      rdsr(1);

      wrsr(8'h41);
      rdsr(2);
      wrsr(8'hFF);
      check("status_c1", status, 8'hC1);
      rdsr(1);

      wrsr(8'h41);
      d = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      mwrite(16'h0010, d, 0);
      mread(16'h0010, 4);

      d = '{8'h11, 8'h22};
      mwrite(16'h1FFF, d, 0);
      mread(16'h0000, 1);
      mread(16'h1FFF, 2);

      wrsr(8'h80);
      d = '{8'h77};
      mwrite(16'h0020, d, 0);
      d = '{8'hA5, 8'h5A};
      mwrite(16'h001F, d, 0);
      mread(16'h0000, 1);
      mread(16'h0020, 1);
      mread(16'h001F, 3);

      wrsr(8'h41);
      d = '{8'h3C};
      mwrite(16'h0004, d, 0);
      d = '{};
      mwrite(16'h0004, d, 4);
      mread(16'h0004, 1);

      h = '{8'h9F, 8'h55, 8'hAA, 8'h00};
      txn(h, 0, 0);
      check("status_after_9f", status, st_m);

      // Reset in the middle of a write data byte
      spi_cs_n = 1'b0;
      #HALF;
      zero_en = 1'b1;
      spi_bits(8'h02, 8);
      spi_bits(8'h00, 8);
      spi_bits(8'h04, 8);
      spi_bits(8'hC3, 4);
      zero_en = 1'b0;
      reset_n = 1'b0;
      st_m = 8'h00;
      #50 spi_cs_n = 1'b1;
      #50 reset_n = 1'b1;
      #(2*HALF);
      check("status_after_reset", status, 8'h00);
      mread(16'h0004, 2);

      // Randomized traffic across all address modes
      for (int it = 0; it < 16; it++) begin
         wrsr(8'($urandom));
         addr = int'($urandom_range(0, 65535));
         n = int'($urandom_range(1, 5));
         d = '{};
         repeat (n) d.push_back(8'($urandom));
         mwrite(addr, d, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0);
         mread(addr, n);
      end
      rdsr(3);

      #200;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
